// File: rtl/vpu_req_arbiter.sv
// Round-robin arbiter sharing one VPU request port between NUM_REQ host requesters.
// Keeps an in-order tag FIFO of issued requesters and routes VPU completions back to them.
module vpu_req_arbiter #(
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned INSTR_WIDTH     = 32,
   parameter int unsigned STREAM_ID_WIDTH = 4,
   parameter int unsigned OUTSTD_DEPTH    = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_REQ-1:0]                   req_valid_i,
   output logic [NUM_REQ-1:0]                   req_ready_o,
   input  logic [NUM_REQ*INSTR_WIDTH-1:0]       req_instr_i,
   input  logic [NUM_REQ*STREAM_ID_WIDTH-1:0]   req_stream_id_i,
   output logic                                 vpu_valid_o,
   input  logic                                 vpu_ready_i,
   output logic [INSTR_WIDTH-1:0]               vpu_instr_o,
   output logic [STREAM_ID_WIDTH-1:0]           vpu_stream_id_o,
   input  logic                                 vpu_resp_valid_i,
   output logic [NUM_REQ-1:0]                   resp_valid_o,
   output logic [$clog2(OUTSTD_DEPTH):0]        outstanding_o,
   output logic                                 err_o
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned PtrW = $clog2(OUTSTD_DEPTH);
   localparam logic [IdxW-1:0] IdxOne = IdxW'(1);
   localparam logic [PtrW:0]   PtrOne = (PtrW + 1)'(1);

   typedef enum logic [0:0] {StIdle, StIssue} state_e;

   state_e                     state_q;
   logic [IdxW-1:0]            rr_ptr_q;
   logic [IdxW-1:0]            winner_q;
   logic [INSTR_WIDTH-1:0]     instr_q;
   logic [STREAM_ID_WIDTH-1:0] sid_q;
   logic                       vpu_valid_q;
   logic [NUM_REQ-1:0]         resp_valid_q;
   logic                       err_q;
   logic [PtrW:0]              wr_ptr_q;
   logic [PtrW:0]              rd_ptr_q;
   logic [IdxW-1:0]            tag_mem_q [OUTSTD_DEPTH];

   logic            fifo_empty;
   logic            fifo_full;
   logic            push;
   logic            pop;
   logic            grant;
   logic            win_found;
   logic [IdxW-1:0] win_idx;
   logic [IdxW-1:0] cand;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]) &&
                       (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);
   // Empty is judged on pre-update pointers, so a same-cycle push cannot satisfy a pop.
   assign pop  = vpu_resp_valid_i && !fifo_empty;
   assign push = (state_q == StIssue) && vpu_ready_i;

   // First asserted requester scanning upward from rr_ptr_q, wrapping via IdxW-bit overflow.
   always_comb begin
      win_found = 1'b0;
      win_idx   = rr_ptr_q;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = rr_ptr_q + IdxW'(i);
         if (!win_found && req_valid_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // A completion freeing a slot in this cycle lets the grant through while full.
   assign grant       = (state_q == StIdle) && win_found && (!fifo_full || pop);
   assign req_ready_o = grant ? (NUM_REQ'(1) << win_idx) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         rr_ptr_q     <= '0;
         winner_q     <= '0;
         instr_q      <= '0;
         sid_q        <= '0;
         vpu_valid_q  <= 1'b0;
         resp_valid_q <= '0;
         err_q        <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         for (int unsigned i = 0; i < OUTSTD_DEPTH; i++) begin
            tag_mem_q[i] <= '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant) begin
                  winner_q    <= win_idx;
                  instr_q     <= req_instr_i[win_idx*INSTR_WIDTH +: INSTR_WIDTH];
                  sid_q       <= req_stream_id_i[win_idx*STREAM_ID_WIDTH +: STREAM_ID_WIDTH];
                  vpu_valid_q <= 1'b1;
                  state_q     <= StIssue;
               end
            end
            StIssue: begin
               if (push) begin
                  tag_mem_q[wr_ptr_q[PtrW-1:0]] <= winner_q;
                  wr_ptr_q    <= wr_ptr_q + PtrOne;
                  rr_ptr_q    <= winner_q + IdxOne;
                  vpu_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase

         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
         end
         resp_valid_q <= pop ? (NUM_REQ'(1) << tag_mem_q[rd_ptr_q[PtrW-1:0]]) : '0;
         if (vpu_resp_valid_i && fifo_empty) begin
            err_q <= 1'b1;
         end
      end
   end

   assign vpu_valid_o     = vpu_valid_q;
   assign vpu_instr_o     = instr_q;
   assign vpu_stream_id_o = sid_q;
   assign resp_valid_o    = resp_valid_q;
   assign outstanding_o   = wr_ptr_q - rd_ptr_q;
   assign err_o           = err_q;

endmodule
